// File: rtl/iq_wakeup.sv
// Issue-queue operand readiness tracker: per-entry rs1/rs2 tag, status and early-wakeup countdown.
// Optional macro IQ_WAKEUP_CANCEL_EN enables speculative-wakeup cancellation.
module iq_wakeup #(
  parameter int unsigned IQ_DEPTH = 16,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned LAT_W    = 3
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic                         flush,
  input  logic                         disp_valid,
  input  logic [$clog2(IQ_DEPTH)-1:0]  disp_idx,
  input  logic [TAG_W-1:0]             disp_rs1_tag,
  input  logic                         disp_rs1_rdy,
  input  logic [TAG_W-1:0]             disp_rs2_tag,
  input  logic                         disp_rs2_rdy,
  input  logic                         wake_valid,
  input  logic [TAG_W-1:0]             wake_tag,
  input  logic [LAT_W-1:0]             wake_lat,
  input  logic                         wb_valid,
  input  logic [TAG_W-1:0]             wb_tag,
  input  logic                         cancel_valid,
  input  logic [TAG_W-1:0]             cancel_tag,
  input  logic                         issue_valid,
  input  logic [$clog2(IQ_DEPTH)-1:0]  issue_idx,
  output logic [IQ_DEPTH-1:0]          valid,
  output logic [IQ_DEPTH-1:0][1:0]     rs1_stat,
  output logic [IQ_DEPTH-1:0][1:0]     rs2_stat
);

  localparam int unsigned IDX_W = $clog2(IQ_DEPTH);

  typedef enum logic [1:0] {
    REG_READY = 2'b00,
    REG_MAY   = 2'b01,
    REG_WAIT  = 2'b10
  } reg_stat_e;

  logic [IQ_DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q [IQ_DEPTH][2];
  logic [TAG_W-1:0]    tag_d [IQ_DEPTH][2];
  reg_stat_e           st_q  [IQ_DEPTH][2];
  reg_stat_e           st_d  [IQ_DEPTH][2];
  logic [LAT_W-1:0]    cnt_q [IQ_DEPTH][2];
  logic [LAT_W-1:0]    cnt_d [IQ_DEPTH][2];

  logic [TAG_W-1:0] d_tag [2];
  logic             d_rdy [2];
  logic             cancel_hit;

  assign d_tag[0] = disp_rs1_tag;
  assign d_tag[1] = disp_rs2_tag;
  assign d_rdy[0] = disp_rs1_rdy;
  assign d_rdy[1] = disp_rs2_rdy;

`ifndef IQ_WAKEUP_CANCEL_EN
  logic unused_cancel;
  assign unused_cancel = ^{cancel_valid, cancel_tag};
`endif

  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    st_d       = st_q;
    cnt_d      = cnt_q;
    cancel_hit = 1'b0;
    for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
      if (flush) begin
        valid_d[i] = 1'b0;
        for (int unsigned j = 0; j < 2; j++) begin
          st_d[i][j]  = REG_WAIT;
          cnt_d[i][j] = '0;
        end
      end else if (disp_valid && disp_idx == IDX_W'(i)) begin
        valid_d[i] = 1'b1;
        for (int unsigned j = 0; j < 2; j++) begin
          tag_d[i][j] = d_tag[j];
          cnt_d[i][j] = '0;
          st_d[i][j]  = (d_rdy[j] || (wb_valid && wb_tag == d_tag[j])) ? REG_READY : REG_WAIT;
        end
      end else if ((issue_valid && issue_idx == IDX_W'(i)) || !valid_q[i]) begin
        valid_d[i] = 1'b0;
        for (int unsigned j = 0; j < 2; j++) begin
          st_d[i][j]  = REG_WAIT;
          cnt_d[i][j] = '0;
        end
      end else begin
        for (int unsigned j = 0; j < 2; j++) begin
`ifdef IQ_WAKEUP_CANCEL_EN
          cancel_hit = cancel_valid && (tag_q[i][j] == cancel_tag);
`else
          cancel_hit = 1'b0;
`endif
          if (wb_valid && tag_q[i][j] == wb_tag) begin
            st_d[i][j]  = REG_READY;
            cnt_d[i][j] = '0;
          end else if (cancel_hit) begin
            // A cancel on this tag also masks any same-cycle wakeup of it
            if (st_q[i][j] == REG_MAY || cnt_q[i][j] != '0) begin
              st_d[i][j]  = REG_WAIT;
              cnt_d[i][j] = '0;
            end
          end else if (wake_valid && tag_q[i][j] == wake_tag &&
                       st_q[i][j] == REG_WAIT && cnt_q[i][j] == '0) begin
            // lat==1 loads the counter too, so MAY always resolves via countdown
            cnt_d[i][j] = wake_lat;
            if (wake_lat == '0)
              st_d[i][j] = REG_READY;
            else if (wake_lat == LAT_W'(1))
              st_d[i][j] = REG_MAY;
            else
              st_d[i][j] = REG_WAIT;
          end else if (cnt_q[i][j] != '0) begin
            cnt_d[i][j] = cnt_q[i][j] - LAT_W'(1);
            if (cnt_q[i][j] == LAT_W'(2))
              st_d[i][j] = REG_MAY;
            else if (cnt_q[i][j] == LAT_W'(1))
              st_d[i][j] = REG_READY;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
        for (int unsigned j = 0; j < 2; j++) begin
          tag_q[i][j] <= '0;
          st_q[i][j]  <= REG_WAIT;
          cnt_q[i][j] <= '0;
        end
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    valid = valid_q;
    for (int unsigned i = 0; i < IQ_DEPTH; i++) begin
      rs1_stat[i] = st_q[i][0];
      rs2_stat[i] = st_q[i][1];
    end
  end

endmodule

// File: tb/tb_iq_wakeup.sv
// Bench for iq_wakeup: directed vectors plus a cycle-by-cycle "cycles until ready" operand model.
module tb_iq_wakeup;
  localparam int D = 16;

`ifdef IQ_WAKEUP_CANCEL_EN
  localparam bit CANCEL = 1'b1;
  localparam logic [1:0] CAN_EXP = 2'b10;
`else
  localparam bit CANCEL = 1'b0;
  localparam logic [1:0] CAN_EXP = 2'b00;
`endif

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  logic flush, disp_valid, disp_rs1_rdy, disp_rs2_rdy;
  logic [3:0] disp_idx, issue_idx;
  logic [5:0] disp_rs1_tag, disp_rs2_tag, wake_tag, wb_tag, cancel_tag;
  logic [2:0] wake_lat;
  logic wake_valid, wb_valid, cancel_valid, issue_valid;
  logic [D-1:0] valid;
  logic [D-1:0][1:0] rs1_stat, rs2_stat;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  iq_wakeup #(.IQ_DEPTH(16), .TAG_W(6), .LAT_W(3)) dut (
    .clk(clk), .reset_(reset_), .flush(flush),
    .disp_valid(disp_valid), .disp_idx(disp_idx),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs1_rdy(disp_rs1_rdy),
    .disp_rs2_tag(disp_rs2_tag), .disp_rs2_rdy(disp_rs2_rdy),
    .wake_valid(wake_valid), .wake_tag(wake_tag), .wake_lat(wake_lat),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .cancel_valid(cancel_valid), .cancel_tag(cancel_tag),
    .issue_valid(issue_valid), .issue_idx(issue_idx),
    .valid(valid), .rs1_stat(rs1_stat), .rs2_stat(rs2_stat)
  );

  // Model: each operand keeps the number of cycles until its value is usable,
  // -1 meaning "no producer scheduled yet".
  bit         mv   [D];
  logic [5:0] mtag [D][2];
  int         eta  [D][2];

  function automatic logic [1:0] st(int e);
    return (e == 0) ? 2'b00 : (e == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic int disp_eta(logic [5:0] t, logic r);
    return (r || (wb_valid && wb_tag == t)) ? 0 : -1;
  endfunction

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < D; i++) begin
        mv[i] = 1'b0;
        for (int j = 0; j < 2; j++) begin mtag[i][j] = '0; eta[i][j] = -1; end
      end
    end else if (flush) begin
      for (int i = 0; i < D; i++) begin
        mv[i] = 1'b0;
        for (int j = 0; j < 2; j++) eta[i][j] = -1;
      end
    end else begin
      for (int i = 0; i < D; i++) begin
        if (disp_valid && int'(disp_idx) == i) begin
          mv[i] = 1'b1;
          mtag[i][0] = disp_rs1_tag;
          mtag[i][1] = disp_rs2_tag;
          eta[i][0] = disp_eta(disp_rs1_tag, disp_rs1_rdy);
          eta[i][1] = disp_eta(disp_rs2_tag, disp_rs2_rdy);
        end else if ((issue_valid && int'(issue_idx) == i) || !mv[i]) begin
          mv[i] = 1'b0;
          for (int j = 0; j < 2; j++) eta[i][j] = -1;
        end else begin
          for (int j = 0; j < 2; j++) begin
            if (wb_valid && wb_tag == mtag[i][j]) eta[i][j] = 0;
            else if (CANCEL && cancel_valid && cancel_tag == mtag[i][j]) begin
              if (eta[i][j] > 0) eta[i][j] = -1;
            end else if (wake_valid && wake_tag == mtag[i][j] && eta[i][j] < 0)
              eta[i][j] = int'(wake_lat);
            else if (eta[i][j] > 0) eta[i][j] = eta[i][j] - 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [D-1:0] ev;
    logic [D-1:0][1:0] e1, e2;
    for (int i = 0; i < D; i++) begin
      ev[i] = mv[i];
      e1[i] = st(eta[i][0]);
      e2[i] = st(eta[i][1]);
    end
    total += 3;
    if (valid !== ev) begin
      bad++;
      $display("FAIL model_valid t=%0t got=%h exp=%h", $time, valid, ev);
    end
    if (rs1_stat !== e1) begin
      bad++;
      $display("FAIL model_rs1 t=%0t got=%h exp=%h", $time, rs1_stat, e1);
    end
    if (rs2_stat !== e2) begin
      bad++;
      $display("FAIL model_rs2 t=%0t got=%h exp=%h", $time, rs2_stat, e2);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; wake_valid = 1'b0; wb_valid = 1'b0;
    cancel_valid = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic disp(int idx, int t1, bit r1, int t2, bit r2);
    disp_valid = 1'b1; disp_idx = 4'(idx);
    disp_rs1_tag = 6'(t1); disp_rs1_rdy = r1;
    disp_rs2_tag = 6'(t2); disp_rs2_rdy = r2;
  endtask

  task automatic wake(int t, int lat);
    wake_valid = 1'b1; wake_tag = 6'(t); wake_lat = 3'(lat);
  endtask

  task automatic wb(int t);
    wb_valid = 1'b1; wb_tag = 6'(t);
  endtask

  task automatic cancel(int t);
    cancel_valid = 1'b1; cancel_tag = 6'(t);
  endtask

  task automatic issue(int idx);
    issue_valid = 1'b1; issue_idx = 4'(idx);
  endtask

  initial begin
    idle();
    disp_idx = '0; issue_idx = '0; disp_rs1_tag = '0; disp_rs2_tag = '0;
    disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
    wake_tag = '0; wake_lat = '0; wb_tag = '0; cancel_tag = '0;
    reset_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_rs1", 32'(rs1_stat), 32'hAAAA_AAAA);
    reset_ = 1'b1;

    // Dispatch with rs1 ready, rs2 waiting on tag 5, then writeback of 5
    disp(3, 1, 1'b1, 5, 1'b0); step();
    chk("disp_valid3", 32'(valid[3]), 32'h1);
    chk("disp_rs1_3", 32'(rs1_stat[3]), 32'h0);
    chk("disp_rs2_3", 32'(rs2_stat[3]), 32'h2);
    wb(5); step();
    chk("wb_rs2_3", 32'(rs2_stat[3]), 32'h0);

    // Early wakeup latency 3 on tag 9
    disp(4, 9, 1'b0, 10, 1'b1); step();
    wake(9, 3); step();
    chk("lat3_c1", 32'(rs1_stat[4]), 32'h2);
    step();
    chk("lat3_c2", 32'(rs1_stat[4]), 32'h2);
    step();
    chk("lat3_c3", 32'(rs1_stat[4]), 32'h1);
    chk("model_lat3_c3", 32'(st(eta[4][0])), 32'h1);
    step();
    chk("lat3_c4", 32'(rs1_stat[4]), 32'h0);

    // Cancel of a MAY operand
    disp(5, 9, 1'b0, 11, 1'b0); step();
    wake(9, 2); step();
    chk("lat2_c1", 32'(rs1_stat[5]), 32'h2);
    step();
    chk("lat2_may", 32'(rs1_stat[5]), 32'h1);
    chk("ready_unaffected", 32'(rs1_stat[4]), 32'h0);
    cancel(9); step();
    chk("cancel_may", 32'(rs1_stat[5]), 32'(CAN_EXP));
    step();
    chk("cancel_hold", 32'(rs1_stat[5]), 32'(CAN_EXP));
    wake(9, 0); step();
    chk("rewake_lat0", 32'(rs1_stat[5]), 32'h0);
    wake(11, 0); cancel(11); step();
    chk("wake_vs_cancel", 32'(rs2_stat[5]), 32'(CAN_EXP));

    // Dispatch bypass from writeback; same-cycle wakeup ignored
    disp(2, 7, 1'b0, 8, 1'b0); wb(7); wake(8, 0); step();
    chk("bypass_rs1_2", 32'(rs1_stat[2]), 32'h0);
    chk("nowake_rs2_2", 32'(rs2_stat[2]), 32'h2);
    chk("model_bypass", 32'(st(eta[2][0])), 32'h0);
    disp(2, 7, 1'b0, 8, 1'b0); issue(2); step();
    chk("disp_issue_valid2", 32'(valid[2]), 32'h1);
    chk("redisp_rs1_2", 32'(rs1_stat[2]), 32'h2);
    issue(3); step();
    chk("issue_valid3", 32'(valid[3]), 32'h0);
    chk("issue_rs1_3", 32'(rs1_stat[3]), 32'h2);
    wb(1); step();
    chk("invalid_ignores_wb", 32'(rs1_stat[3]), 32'h2);

    // Fill all entries, then flush with a simultaneous dispatch
    for (int i = 0; i < D; i++) begin
      disp(i, i, 1'b1, i + 1, 1'b0); step();
    end
    chk("full_valid", 32'(valid), 32'h0000_FFFF);
    flush = 1'b1; disp(0, 3, 1'b1, 4, 1'b1); step();
    chk("flush_valid", 32'(valid), 32'h0);
    chk("flush_rs1", 32'(rs1_stat), 32'hAAAA_AAAA);
    chk("flush_rs2", 32'(rs2_stat), 32'hAAAA_AAAA);

    // Asynchronous reset in the middle of operation
    disp(0, 1, 1'b1, 2, 1'b1); step();
    disp(1, 3, 1'b1, 4, 1'b0); step();
    chk("pre_reset_valid", 32'(valid), 32'h3);
    reset_ = 1'b0;
    #1;
    chk("async_reset_valid", 32'(valid), 32'h0);
    chk("async_reset_rs1", 32'(rs1_stat), 32'hAAAA_AAAA);
    step();
    reset_ = 1'b1;
    step();
    chk("post_reset_valid", 32'(valid), 32'h0);
    chk("post_reset_rs2", 32'(rs2_stat), 32'hAAAA_AAAA);

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iq_wakeup.md
Name: iq_wakeup

Overview:
Per-entry operand readiness tracker for the issue queue. It produces the rs1_stat, rs2_stat and valid vectors that the issue selector reads.
- Captures source tags at dispatch.
- Applies early (latency-scheduled) wakeups and writeback broadcasts.
- Reverts speculative wakeups on cancel.
- Clears entries on issue or flush.

Parameters:
IQ_DEPTH, `IqDepth (16), number of issue queue entries
TAG_W, 6, physical register tag width
LAT_W, 3, width of early-wakeup latency field and per-operand countdown

Ports:
clk  in  1  core clock
reset_  in  1  asynchronous active-low reset
flush  in  1  clear every entry
disp_valid  in  1  dispatch one instruction
disp_idx  in  $clog2(IQ_DEPTH)  entry written by dispatch
disp_rs1_tag  in  TAG_W  rs1 source tag
disp_rs1_rdy  in  1  rs1 already available in register file
disp_rs2_tag  in  TAG_W  rs2 source tag
disp_rs2_rdy  in  1  rs2 already available in register file
wake_valid  in  1  early wakeup broadcast
wake_tag  in  TAG_W  producer tag
wake_lat  in  LAT_W  cycles until result is on bypass
wb_valid  in  1  writeback broadcast (value final)
wb_tag  in  TAG_W  writeback tag
cancel_valid  in  1  speculative producer cancelled (load miss)
cancel_tag  in  TAG_W  cancelled tag
issue_valid  in  1  entry issued this cycle
issue_idx  in  $clog2(IQ_DEPTH)  issued entry
valid  out  IQ_DEPTH  entry occupied
rs1_stat  out  RegStat_t[IQ_DEPTH]  rs1 status per entry
rs2_stat  out  RegStat_t[IQ_DEPTH]  rs2 status per entry

Behaviour:
- RegStat_t encoding: REG_READY=2'b00; REG_MAY=2'b01 (ready next cycle); REG_WAIT=2'b10. Bit1 is `RegStatReady_, active low.
- All outputs are registered. Updates are visible in the cycle after the triggering input.
- Reset (async, reset_=0):
  - valid=0.
  - All stat=REG_WAIT.
  - All counters=0.
  - Tags=0.
- Per operand: tag, 2-bit state, LAT_W countdown. rs1 and rs2 are updated independently with identical rules.
- Dispatch at disp_idx:
  - valid=1; tag is stored.
  - state=READY if disp_rsN_rdy, or if wb_valid with wb_tag==disp tag in the same cycle (bypass).
  - Otherwise state=WAIT, counter=0.
  - A same-cycle early wakeup is not applied to the dispatching entry.
- Early wakeup on a valid entry whose operand is in WAIT with tag==wake_tag and counter==0:
  - wake_lat==0 -> READY.
  - wake_lat==1 -> MAY.
  - wake_lat>=2 -> counter=wake_lat, state stays WAIT.
- Countdown: each cycle a counter is nonzero it decrements.
  - Counter reaching 1 -> MAY.
  - Counter reaching 0 from 1 -> READY.
- Writeback match (valid entry, tag==wb_tag): state -> READY, counter=0, regardless of current state.
- Cancel match (valid entry, state MAY or counter!=0, tag==cancel_tag): state -> WAIT, counter=0. READY operands are unaffected.
- Issue: valid[issue_idx]=0; stats -> WAIT.
- Priority per entry, highest first: flush > dispatch > issue > writeback > cancel > early wakeup > countdown.
  - Dispatch and issue on the same idx: dispatch wins and the entry stays valid.
  - Wakeup and cancel of the same tag in the same cycle: cancel wins.
- Flush: next cycle all valid=0, all stat=WAIT, all counters=0. A flush overrides a same-cycle dispatch.
- Invalid entries ignore broadcasts. Their stat is held at WAIT.
- Tag 0 is a normal tag. No special handling.

Optional Feature:
Macro IQ_WAKEUP_CANCEL_EN.
- Defined: cancel_valid/cancel_tag are honoured as above.
- Undefined:
  - Cancel ports are present but ignored.
  - Early wakeups are non-speculative.
  - Cancel logic is not synthesised.

Test Plan:
- Reset mid-operation: assert reset_=0 with entries valid -> valid=0 and all stat=2'b10 immediately (async), held after release.
- Dispatch idx=3, rs1_rdy=1, rs2 tag=5 not ready -> next cycle valid[3]=1, rs1_stat[3]=00, rs2_stat[3]=10. Then wb tag=5 -> rs2_stat[3]=00 one cycle later.
- Entry waiting on tag 9, wake_lat=3 -> WAIT for 2 cycles, MAY on the 3rd, READY on the 4th.
- Cancel (macro defined): wake tag 9 lat=2, cancel tag 9 while MAY -> stat back to 10, counter 0. With macro undefined, the same stimulus reaches READY.
- Dispatch idx=2 tag 7 in the same cycle as wb tag 7 -> rs1_stat[2]=00 next cycle. Dispatch+issue same idx=2 -> valid[2] stays 1.
- Flush with 16 valid entries plus a simultaneous dispatch -> all valid=0 next cycle.
